// File: rtl/roam_pkg.sv
// roam_pkg: shared types, keycodes and box geometry helpers for the roaming controller.
package roam_pkg;
    typedef enum logic [1:0] {UP, DOWN, LEFT, RIGHT} dir_t;
    typedef enum logic [1:0] {IDLE, TURN, WALK, LOCK} roam_state_t;
    localparam logic [7:0] KEY_W     = 8'h1A;
    localparam logic [7:0] KEY_A     = 8'h04;
    localparam logic [7:0] KEY_S     = 8'h16;
    localparam logic [7:0] KEY_D     = 8'h07;
    localparam logic [7:0] KEY_ENTER = 8'h28;
    typedef struct packed {
        logic [10:0] left;
        logic [10:0] right;
        logic [10:0] top;
        logic [10:0] bot;
    } box_t;
    function automatic box_t make_box(input logic [10:0] x, input logic [10:0] y,
                                      input logic [10:0] w, input logic [10:0] h);
        return '{left: x, right: x + w, top: y, bot: y + h};
    endfunction
    function automatic logic [10:0] abs_diff(input logic [10:0] a, input logic [10:0] b);
        return a > b ? a - b : b - a;
    endfunction
    // Trainer box t faces NPC box n: aligned within r and separated by a gap of 0..r.
    function automatic logic in_reach(input dir_t d, input box_t t, input box_t n, input logic [10:0] r);
        logic [10:0] near_e, far_e, perp;
        near_e = d == UP ? n.bot : d == DOWN ? t.bot : d == LEFT ? n.right : t.right;
        far_e  = d == UP ? t.top : d == DOWN ? n.top : d == LEFT ? t.left : n.left;
        perp   = (d == UP || d == DOWN) ? abs_diff(t.left, n.left) : abs_diff(t.top, n.top);
        return perp <= r && far_e >= near_e && far_e - near_e <= r;
    endfunction
    function automatic logic is_dir_key(input logic [7:0] k);
        return k == KEY_W || k == KEY_A || k == KEY_S || k == KEY_D;
    endfunction
    function automatic dir_t key_dir(input logic [7:0] k);
        return k == KEY_S ? DOWN : k == KEY_A ? LEFT : k == KEY_D ? RIGHT : UP;
    endfunction
endpackage

// File: rtl/roam_box_hit.sv
// roam_box_hit: inclusive-edge overlap test between two boxes.
module roam_box_hit
    import roam_pkg::*;
(
    input  box_t a,
    input  box_t b,
    output logic hit
);
    assign hit = a.left <= b.right && b.left <= a.right && a.top <= b.bot && b.top <= a.bot;
endmodule

// File: rtl/roam_ctrl.sv
// roam_ctrl: tile-stepping overworld trainer movement with NPC collision,
// walk animation and battle trigger on ENTER.
module roam_ctrl
    import roam_pkg::*;
#(
    parameter int NUM_NPC    = 5,
    parameter int TILE       = 16,
    parameter int STEP       = 1,
    parameter int MAP_X      = 300,
    parameter int MAP_Y      = 100,
    parameter int MAP_W      = 192,
    parameter int MAP_H      = 255,
    parameter int TOP_MARGIN = 25,
    parameter int SPR_W      = 14,
    parameter int SPR_H      = 16,
    parameter int START_X    = 387,
    parameter int START_Y    = 336,
    parameter int REACH      = 3,
    parameter int ANIM_DIV   = 4,
    localparam int IW        = NUM_NPC > 1 ? $clog2(NUM_NPC) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic                  frame_clk,
    input  logic                  is_roam,
    input  logic [7:0]            keycode,
    input  logic [NUM_NPC*10-1:0] npc_x,
    input  logic [NUM_NPC*10-1:0] npc_y,
    input  logic [NUM_NPC-1:0]    npc_active,
    output logic [9:0]            trainer_x,
    output logic [9:0]            trainer_y,
    output logic [1:0]            trainer_dir,
    output logic [1:0]            walk_frame,
    output logic                  moving,
    output logic                  start_battle,
    output logic [IW-1:0]         battle_idx
);
    localparam logic [10:0] T11   = 11'(TILE);
    localparam logic [10:0] S11   = 11'(STEP);
    localparam logic [10:0] W11   = 11'(SPR_W);
    localparam logic [10:0] H11   = 11'(SPR_H);
    localparam logic [10:0] R11   = 11'(REACH);
    localparam logic [10:0] X_MIN = 11'(MAP_X);
    localparam logic [10:0] X_MAX = 11'(MAP_X + MAP_W - SPR_W);
    localparam logic [10:0] Y_MIN = 11'(MAP_Y + TOP_MARGIN);
    localparam logic [10:0] Y_MAX = 11'(MAP_Y + MAP_H - SPR_H);
    localparam logic [7:0]  A_END = 8'(ANIM_DIV - 1);

    roam_state_t state_q, state_d;
    dir_t dir_q, dir_d;
    logic [9:0] x_q, x_d, y_q, y_d;
    logic [10:0] remain_q, remain_d;
    logic [7:0] anim_q, anim_d;
    logic [1:0] frame_q, frame_d;
    logic [IW-1:0] idx_q, idx_d;
    logic start_q, start_d;
    logic [2:0] sync_q;
    logic tick_q;
    logic [10:0] cx, cy, dx, dy, mv;
    box_t here, dest;
    logic [NUM_NPC-1:0] block, elig;
    logic [IW-1:0] win;
    logic found, in_map;

    // Left/up moves near 0 wrap to huge 11-bit values and so fail the bound check.
    assign cx     = {1'b0, x_q};
    assign cy     = {1'b0, y_q};
    assign dx     = dir_q == LEFT ? cx - T11 : dir_q == RIGHT ? cx + T11 : cx;
    assign dy     = dir_q == UP ? cy - T11 : dir_q == DOWN ? cy + T11 : cy;
    assign here   = make_box(cx, cy, W11, H11);
    assign dest   = make_box(dx, dy, W11, H11);
    assign in_map = dx >= X_MIN && dx <= X_MAX && dy >= Y_MIN && dy <= Y_MAX;
    assign mv     = remain_q < S11 ? remain_q : S11;

    for (genvar i = 0; i < NUM_NPC; i++) begin : g_npc
        box_t npc;
        logic hit;
        assign npc = make_box({1'b0, npc_x[i*10 +: 10]}, {1'b0, npc_y[i*10 +: 10]}, W11, H11);
        roam_box_hit u_hit (.a(dest), .b(npc), .hit(hit));
        assign block[i] = npc_active[i] & hit;
        assign elig[i]  = npc_active[i] & in_reach(dir_q, here, npc, R11);
    end

    always_comb begin
        win   = '0;
        found = 1'b0;
        for (int k = NUM_NPC - 1; k >= 0; k--) begin
            if (elig[k]) begin
                win   = IW'(k);
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        dir_d    = dir_q;
        x_d      = x_q;
        y_d      = y_q;
        remain_d = remain_q;
        anim_d   = anim_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        start_d  = 1'b0;
        if (!is_roam) begin
            state_d  = IDLE;
            dir_d    = UP;
            x_d      = 10'(START_X);
            y_d      = 10'(START_Y);
            remain_d = '0;
            anim_d   = '0;
            frame_d  = '0;
            idx_d    = '0;
        end else if (state_q == IDLE) begin
            if (keycode == KEY_ENTER) begin
                if (found) begin
                    start_d = 1'b1;
                    idx_d   = win;
                    state_d = LOCK;
                end
            end else if (tick_q && is_dir_key(keycode)) begin
                if (key_dir(keycode) != dir_q) begin
                    dir_d   = key_dir(keycode);
                    state_d = TURN;
                end else if (in_map && !(|block)) begin
                    remain_d = T11;
                    state_d  = WALK;
                end
            end
        end else if (state_q == TURN) begin
            if (tick_q) state_d = IDLE;
        end else if (state_q == WALK && tick_q) begin
            x_d      = dir_q == LEFT ? x_q - mv[9:0] : dir_q == RIGHT ? x_q + mv[9:0] : x_q;
            y_d      = dir_q == UP ? y_q - mv[9:0] : dir_q == DOWN ? y_q + mv[9:0] : y_q;
            remain_d = remain_q - mv;
            state_d  = remain_d == '0 ? IDLE : WALK;
            anim_d   = anim_q == A_END ? '0 : anim_q + 8'd1;
            frame_d  = anim_q == A_END ? frame_q + 2'd1 : frame_q;
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync_q   <= '0;
            tick_q   <= 1'b0;
            state_q  <= IDLE;
            dir_q    <= UP;
            x_q      <= 10'(START_X);
            y_q      <= 10'(START_Y);
            remain_q <= '0;
            anim_q   <= '0;
            frame_q  <= '0;
            idx_q    <= '0;
            start_q  <= 1'b0;
        end else begin
            sync_q   <= {sync_q[1:0], frame_clk};
            tick_q   <= sync_q[1] & ~sync_q[2];
            state_q  <= state_d;
            dir_q    <= dir_d;
            x_q      <= x_d;
            y_q      <= y_d;
            remain_q <= remain_d;
            anim_q   <= anim_d;
            frame_q  <= frame_d;
            idx_q    <= idx_d;
            start_q  <= start_d;
        end
    end

    assign trainer_x    = x_q;
    assign trainer_y    = y_q;
    assign trainer_dir  = dir_q;
    assign walk_frame   = frame_q;
    assign moving       = state_q == WALK;
    assign start_battle = start_q;
    assign battle_idx   = idx_q;
endmodule

// File: tb/tb_roam_ctrl.sv
// tb_roam_ctrl: directed plus randomized checks of roam_ctrl against a pixel-level
// behavioural model of the trainer (position, facing, remaining walk, lock).
module tb_roam_ctrl;
    localparam int NUM_NPC = 5, TILE = 16, STEP = 1, MAP_X = 300, MAP_Y = 100;
    localparam int MAP_W = 192, MAP_H = 255, TOP_MARGIN = 25, SPR_W = 14, SPR_H = 16;
    localparam int START_X = 387, START_Y = 336, REACH = 3, ANIM_DIV = 4;
    localparam logic [7:0] KW = 8'h1A, KA = 8'h04, KS = 8'h16, KD = 8'h07, KE = 8'h28;

    logic Clk, Reset_n, frame_clk, is_roam;
    logic [7:0] keycode;
    logic [NUM_NPC*10-1:0] npc_x, npc_y;
    logic [NUM_NPC-1:0] npc_active;
    logic [9:0] trainer_x, trainer_y;
    logic [1:0] trainer_dir, walk_frame;
    logic moving, start_battle;
    logic [2:0] battle_idx;

    int checks = 0, errors = 0;
    int mx, my, mdir, m_left, m_walks, m_idx;
    bit m_turn, m_lock;
    int nx[NUM_NPC], ny[NUM_NPC];
    int ddx[4] = '{0, 0, -1, 1};
    int ddy[4] = '{-1, 1, 0, 0};
    logic [7:0] keys[4] = '{KW, KS, KA, KD};

    roam_ctrl dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .is_roam(is_roam),
        .keycode(keycode), .npc_x(npc_x), .npc_y(npc_y), .npc_active(npc_active),
        .trainer_x(trainer_x), .trainer_y(trainer_y), .trainer_dir(trainer_dir),
        .walk_frame(walk_frame), .moving(moving), .start_battle(start_battle),
        .battle_idx(battle_idx)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation timeout");
    end

    function automatic int iabs(input int v);
        return v < 0 ? -v : v;
    endfunction

    function automatic int kdir(input logic [7:0] k);
        return k == KW ? 0 : k == KS ? 1 : k == KA ? 2 : k == KD ? 3 : -1;
    endfunction

    function automatic bit free_dest();
        int dl, dt;
        dl = mx + ddx[mdir] * TILE;
        dt = my + ddy[mdir] * TILE;
        if (dl < MAP_X || dl > MAP_X + MAP_W - SPR_W || dt < MAP_Y + TOP_MARGIN || dt > MAP_Y + MAP_H - SPR_H)
            return 0;
        for (int i = 0; i < NUM_NPC; i++)
            if (npc_active[i] && dl <= nx[i] + SPR_W && nx[i] <= dl + SPR_W && dt <= ny[i] + SPR_H && ny[i] <= dt + SPR_H)
                return 0;
        return 1;
    endfunction

    function automatic int pick();
        for (int i = 0; i < NUM_NPC; i++) begin
            int perp, gap;
            perp = mdir < 2 ? iabs(mx - nx[i]) : iabs(my - ny[i]);
            case (mdir)
                0: gap = my - (ny[i] + SPR_H);
                1: gap = ny[i] - (my + SPR_H);
                2: gap = mx - (nx[i] + SPR_W);
                default: gap = nx[i] - (mx + SPR_W);
            endcase
            if (npc_active[i] && perp <= REACH && gap >= 0 && gap <= REACH) return i;
        end
        return -1;
    endfunction

    task automatic m_reset();
        mx = START_X; my = START_Y; mdir = 0; m_left = 0; m_walks = 0; m_idx = 0;
        m_turn = 0; m_lock = 0;
    endtask

    task automatic model_tick();
        int k, mv;
        k = kdir(keycode);
        if (m_lock) begin
        end else if (m_turn) begin
            m_turn = 0;
        end else if (m_left > 0) begin
            mv = m_left < STEP ? m_left : STEP;
            mx += ddx[mdir] * mv;
            my += ddy[mdir] * mv;
            m_left -= mv;
            m_walks++;
        end else if (k >= 0) begin
            if (k != mdir) begin
                mdir = k;
                m_turn = 1;
            end else if (free_dest()) begin
                m_left = TILE;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input int exp);
        checks++;
        assert (obs === 32'(exp)) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_x"}, 32'(trainer_x), mx);
        check({tag, "_y"}, 32'(trainer_y), my);
        check({tag, "_dir"}, 32'(trainer_dir), mdir);
        check({tag, "_frame"}, 32'(walk_frame), (m_walks / ANIM_DIV) % 4);
        check({tag, "_moving"}, 32'(moving), int'(m_left > 0));
        check({tag, "_start"}, 32'(start_battle), 0);
        check({tag, "_idx"}, 32'(battle_idx), m_idx);
    endtask

    task automatic set_npc(input int i, input int x, input int y, input bit a);
        nx[i] = x;
        ny[i] = y;
        npc_x[i*10 +: 10] = 10'(x);
        npc_y[i*10 +: 10] = 10'(y);
        npc_active[i] = a;
    endtask

    // One frame: state must still be unchanged when tick is high, then update one cycle later.
    task automatic tick_once();
        int px, py;
        px = mx;
        py = my;
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        #1;
        check("pre_x", 32'(trainer_x), px);
        check("pre_y", 32'(trainer_y), py);
        model_tick();
        @(posedge Clk);
        #1;
        compare_all("tick");
        frame_clk = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int t = 0; t < n; t++) tick_once();
    endtask

    task automatic press_enter(input int n);
        int w;
        w = (!m_lock && !m_turn && m_left == 0) ? pick() : -1;
        keycode = KE;
        for (int c = 0; c < n; c++) begin
            @(posedge Clk);
            #1;
            check("enter_pulse", 32'(start_battle), int'(c == 0 && w >= 0));
            if (c == 0 && w >= 0) begin
                m_lock = 1;
                m_idx = w;
                check("enter_idx", 32'(battle_idx), m_idx);
            end
        end
        keycode = 8'h00;
        @(posedge Clk);
        #1;
        compare_all("enter");
    endtask

    task automatic roam_clear();
        is_roam = 1'b0;
        @(posedge Clk);
        #1;
        is_roam = 1'b1;
        m_reset();
        compare_all("clr");
    endtask

    initial begin
        int r, i, p, g, x, y;
        Reset_n = 1'b0; is_roam = 1'b1; frame_clk = 1'b0; keycode = 8'h00;
        npc_x = '0; npc_y = '0; npc_active = '0;
        for (int n = 0; n < NUM_NPC; n++) set_npc(n, 0, 0, 0);
        m_reset();
        repeat (3) @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        compare_all("rst");
        keycode = KS;
        ticks(3);
        check("s_block_y", 32'(trainer_y), 336);
        check("s_dir", 32'(trainer_dir), 1);
        keycode = KW;
        ticks(19);
        check("w_tile_y", 32'(trainer_y), 320);
        set_npc(0, 389, 212, 1);
        ticks(100);
        check("npc_block_y", 32'(trainer_y), 240);
        npc_active[0] = 1'b0;
        ticks(17);
        check("npc_pass_y", 32'(trainer_y), 224);
        keycode = 8'h00;
        set_npc(0, 389, 203, 1);
        press_enter(1);
        set_npc(0, 389, 206, 1);
        set_npc(3, 389, 205, 1);
        press_enter(3);
        check("lock_idx", 32'(battle_idx), 0);
        keycode = KA;
        ticks(2);
        keycode = KS;
        ticks(2);
        keycode = 8'h00;
        roam_clear();
        npc_active = '0;
        keycode = KW;
        ticks(3);
        roam_clear();
        check("abort_y", 32'(trainer_y), 336);
        ticks(3);
        #2;
        Reset_n = 1'b0;
        #1;
        m_reset();
        compare_all("async");
        @(posedge Clk);
        #1;
        Reset_n = 1'b1;
        for (int it = 0; it < 400; it++) begin
            r = $urandom_range(0, 99);
            if (r < 12) begin
                i = $urandom_range(0, NUM_NPC - 1);
                p = int'($urandom_range(0, 8)) - 4;
                g = int'($urandom_range(0, 6)) - 1;
                case (mdir)
                    0: begin x = mx + p; y = my - SPR_H - g; end
                    1: begin x = mx + p; y = my + SPR_H + g; end
                    2: begin x = mx - SPR_W - g; y = my + p; end
                    default: begin x = mx + SPR_W + g; y = my + p; end
                endcase
                set_npc(i, x, y, $urandom_range(0, 3) != 0);
            end else if (r < 20) begin
                press_enter($urandom_range(1, 3));
            end else if (r < 22) begin
                roam_clear();
            end else begin
                if ($urandom_range(0, 3) == 0) keycode = $urandom_range(0, 4) == 0 ? 8'h00 : keys[$urandom_range(0, 3)];
                tick_once();
            end
            if (m_lock) roam_clear();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
